// File: rtl/im_responder.sv
// Memory-side responder for the image-memory (IM) interface: single outstanding access,
// 24-bit RGB storage, fixed read latency. Define IM_SAT_EN to saturate channels on write.
module im_responder #(
   parameter int AW     = 20,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          im_req,
   input  logic          im_wen_n,
   input  logic [AW-1:0] im_a,
   input  logic [29:0]   im_d,
   output logic [23:0]   im_q,
   output logic          im_ack,
   output logic          im_busy,
   output logic          im_err
);

   localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0]  LAST_CNT = 3'(RD_LAT - 1);
   localparam logic [AW:0] DEPTH_V  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [2:0]    cnt_r;
   logic [2:0]    cnt_nx_s;
   logic [AW-1:0] addr_r;
   logic [29:0]   d_r;
   logic          oor_s;
   logic          mem_we_s;
   logic          q_load_s;
   logic          ack_nx_s;
   logic          err_set_s;
   logic          busy_nx_s;
   logic [23:0]   rd_word_s;
   logic [23:0]   mem_r [DEPTH];

   function automatic logic [7:0] narrow_ch(input logic [9:0] ch);
`ifdef IM_SAT_EN
      narrow_ch = (ch > 10'd255) ? 8'hFF : ch[7:0];
`else
      narrow_ch = ch[7:0];
`endif
   endfunction

   function automatic logic [23:0] narrow_word(input logic [29:0] w);
      narrow_word = {narrow_ch(w[29:20]), narrow_ch(w[19:10]), narrow_ch(w[9:0])};
   endfunction

   assign oor_s     = ({1'b0, addr_r} >= DEPTH_V);
   assign rd_word_s = mem_r[addr_r[IW-1:0]];

   // State register, latency counter and request capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
      if (state_r == ST_IDLE && im_req) begin
         addr_r <= im_a;
         d_r    <= im_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (im_req) begin
               state_nx_s = im_wen_n ? ST_RD : ST_WR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cnt_r == LAST_CNT) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RD;
            end
         end
         ST_WR:   state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Per-state controls feeding the registered outputs and the array
   always_comb begin
      cnt_nx_s  = 3'd0;
      mem_we_s  = 1'b0;
      q_load_s  = 1'b0;
      ack_nx_s  = 1'b0;
      case (state_r)
         ST_IDLE: cnt_nx_s = 3'd0;
         ST_RD: begin
            if (cnt_r == LAST_CNT) begin
               q_load_s = 1'b1;
               ack_nx_s = 1'b1;
            end else begin
               cnt_nx_s = cnt_r + 3'd1;
            end
         end
         ST_WR: begin
            mem_we_s = ~oor_s;
            ack_nx_s = 1'b1;
         end
         default: cnt_nx_s = 3'd0;
      endcase
      err_set_s = ack_nx_s & oor_s;
      busy_nx_s = (state_nx_s != ST_IDLE);
   end

   // Registered interface outputs; im_err is sticky until reset
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q    <= 24'd0;
         im_ack  <= 1'b0;
         im_busy <= 1'b0;
         im_err  <= 1'b0;
      end else begin
         im_ack  <= ack_nx_s;
         im_busy <= busy_nx_s;
         if (q_load_s) begin
            im_q <= oor_s ? 24'd0 : rd_word_s;
         end
         if (err_set_s) begin
            im_err <= 1'b1;
         end
      end
   end

   // Pixel array; contents survive reset, but reset suppresses a pending commit
   always_ff @(posedge clk) begin
      if (mem_we_s && !reset) begin
         mem_r[addr_r[IW-1:0]] <= narrow_word(d_r);
      end
   end

endmodule

// File: tb/tb_im_responder.sv
// Directed self-checking bench for im_responder (default parameters, RD_LAT=2).
module tb_im_responder;

   logic        clk;
   logic        reset;
   logic        im_req;
   logic        im_wen_n;
   logic [19:0] im_a;
   logic [29:0] im_d;
   logic [23:0] im_q;
   logic        im_ack;
   logic        im_busy;
   logic        im_err;

   int tests;
   int fails;
   int lat;
   int acks;
   logic [23:0] q_seen;

   im_responder #(.AW(20), .DEPTH(4096), .RD_LAT(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .im_req   (im_req),
      .im_wen_n (im_wen_n),
      .im_a     (im_a),
      .im_d     (im_d),
      .im_q     (im_q),
      .im_ack   (im_ack),
      .im_busy  (im_busy),
      .im_err   (im_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request at a negedge; lat = cycles from accept edge to the ack cycle, -1 on timeout
   task automatic xfer(input logic wen_n, input logic [19:0] a, input logic [29:0] d);
      im_req   = 1'b1;
      im_wen_n = wen_n;
      im_a     = a;
      im_d     = d;
      lat      = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) im_req = 1'b0;
         if (im_ack) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      im_req   = 1'b1;
      im_wen_n = 1'b1;
      im_a     = 20'h00000;
      im_d     = 30'd0;

      // T1 reset with im_req held high
      repeat (2) @(negedge clk);
      check("t1_ack",  {31'd0, im_ack},  32'd0);
      check("t1_busy", {31'd0, im_busy}, 32'd0);
      check("t1_q",    {8'd0, im_q},     32'd0);
      check("t1_err",  {31'd0, im_err},  32'd0);
      reset  = 1'b0;
      im_req = 1'b0;
      @(negedge clk);

      // T2 write then read back, with latencies
      xfer(1'b0, 20'h00010, {10'd12, 10'd34, 10'd56});
      check("t2_wr_lat", lat, 32'd1);
      @(negedge clk);
      check("t2_ack_single", {31'd0, im_ack}, 32'd0);
      xfer(1'b1, 20'h00010, 30'd0);
      check("t2_rd_lat", lat, 32'd2);
      check("t2_rd_q",   {8'd0, im_q}, 32'h000C2238);
      @(negedge clk);
      check("t2_ack_drop", {31'd0, im_ack}, 32'd0);
      check("t2_q_hold",   {8'd0, im_q},    32'h000C2238);

      // T3 channel narrowing
      xfer(1'b0, 20'h00020, {10'd300, 10'd255, 10'd512});
      check("t3_wr_lat", lat, 32'd1);
      @(negedge clk);
      xfer(1'b1, 20'h00020, 30'd0);
      check("t3_rd_lat", lat, 32'd2);
`ifdef IM_SAT_EN
      check("t3_q", {8'd0, im_q}, 32'h00FFFFFF);
`else
      check("t3_q", {8'd0, im_q}, 32'h002CFF00);
`endif
      @(negedge clk);

      // T4 request pulsed while busy is ignored
      im_req   = 1'b1;
      im_wen_n = 1'b1;
      im_a     = 20'h00010;
      acks     = 0;
      q_seen   = 24'd0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("t4_busy", {31'd0, im_busy}, 32'd1);
            im_a = 20'h00020;
         end
         if (k == 2) im_req = 1'b0;
         if (im_ack) begin
            acks++;
            q_seen = im_q;
         end
      end
      check("t4_acks", acks, 32'd1);
      check("t4_q",    {8'd0, q_seen}, 32'h000C2238);

      // T5 out-of-range accesses
      xfer(1'b0, 20'h00005, {10'd1, 10'd2, 10'd3});
      @(negedge clk);
      check("t5_err_clear", {31'd0, im_err}, 32'd0);
      xfer(1'b1, 20'h01000, 30'd0);
      check("t5_rd_lat", lat, 32'd2);
      check("t5_rd_q",   {8'd0, im_q},   32'h00000000);
      check("t5_err",    {31'd0, im_err}, 32'd1);
      repeat (3) @(negedge clk);
      check("t5_err_sticky", {31'd0, im_err}, 32'd1);
      xfer(1'b0, 20'h01005, {10'd100, 10'd100, 10'd100});
      check("t5_wr_lat", lat, 32'd1);
      @(negedge clk);
      xfer(1'b1, 20'h00005, 30'd0);
      check("t5_alias_q", {8'd0, im_q},   32'h00010203);
      check("t5_err_hold", {31'd0, im_err}, 32'd1);
      @(negedge clk);

      // T6 reset on the commit edge aborts the write
      im_req   = 1'b1;
      im_wen_n = 1'b0;
      im_a     = 20'h00010;
      im_d     = {10'd1, 10'd1, 10'd1};
      acks     = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            im_req = 1'b0;
            reset  = 1'b1;
         end
         if (k == 2) reset = 1'b0;
         if (im_ack) acks++;
      end
      check("t6_acks",  acks, 32'd0);
      check("t6_busy",  {31'd0, im_busy}, 32'd0);
      check("t6_err",   {31'd0, im_err},  32'd0);
      xfer(1'b1, 20'h00010, 30'd0);
      check("t6_rd_lat", lat, 32'd2);
      check("t6_old_q",  {8'd0, im_q}, 32'h000C2238);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
